// File: rtl/awgn_err_check.sv
// Bit-error checker: compares a generator's sample stream against a golden reference
// over one run of N_SAMPLES pairs, and counts mismatching samples and mismatching bits.
module awgn_err_check #(
    parameter int W         = 16,
    parameter int N_SAMPLES = 10000,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [W-1:0]     mask,
    input  logic             dut_valid,
    input  logic [W-1:0]     dut_data,
    output logic             dut_ready,
    input  logic             ref_valid,
    input  logic [W-1:0]     ref_data,
    output logic             ref_ready,
    output logic             busy,
    output logic             done,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_idx,
    output logic [CNT_W-1:0] sample_err_cnt,
    output logic [CNT_W-1:0] bit_err_cnt,
    output logic             first_err_valid,
    output logic [CNT_W-1:0] first_err_idx
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam int               POP_W    = $clog2(W + 1);
    localparam int               SUM_W    = ((CNT_W > POP_W) ? CNT_W : POP_W) + 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t             r_state, w_state_next;
    logic [CNT_W-1:0]   r_idx;
    logic               r_s1_valid;
    logic [W-1:0]       r_s1_x;
    logic [CNT_W-1:0]   r_s1_idx;
    logic               r_err_pulse;
    logic [CNT_W-1:0]   r_err_idx;
    logic [CNT_W-1:0]   r_sample_err_cnt;
    logic [CNT_W-1:0]   r_bit_err_cnt;
    logic               r_first_err_valid;
    logic [CNT_W-1:0]   r_first_err_idx;

    logic               w_fire;
    logic               w_start;
    logic               w_s1_err;
    logic [POP_W-1:0]   w_pop;
    logic [SUM_W-1:0]   w_bit_sum;
    logic [CNT_W-1:0]   w_bit_next;
    logic [CNT_W-1:0]   w_sample_next;

    // Both streams advance together or not at all, so they can never slip apart.
    assign w_fire  = (r_state == S_RUN) && dut_valid && ref_valid;
    assign w_start = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: if (start) w_state_next = S_RUN;
            S_RUN:          if (w_fire && (r_idx == LAST_IDX)) w_state_next = S_DRAIN;
            // Stage 1 already holds the last pair, so one DRAIN cycle lets stage 2 finish.
            S_DRAIN:        w_state_next = S_DONE;
            default:        w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < W; i++) w_pop = w_pop + POP_W'(r_s1_x[i]);
    end

    assign w_s1_err      = r_s1_valid && (|r_s1_x);
    assign w_bit_sum     = SUM_W'(r_bit_err_cnt) + SUM_W'(w_pop);
    assign w_bit_next    = (w_bit_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : CNT_W'(w_bit_sum);
    assign w_sample_next = (r_sample_err_cnt == CNT_MAX) ? CNT_MAX : r_sample_err_cnt + CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // NOTE: the pipeline data is reset along with its valid so outputs are fully defined out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx             <= '0;
            r_s1_valid        <= 1'b0;
            r_s1_x            <= '0;
            r_s1_idx          <= '0;
            r_err_pulse       <= 1'b0;
            r_err_idx         <= '0;
            r_sample_err_cnt  <= '0;
            r_bit_err_cnt     <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_idx   <= '0;
        end else begin
            r_err_pulse <= 1'b0;
            if (w_start) begin
                r_idx             <= '0;
                r_s1_valid        <= 1'b0;
                r_err_idx         <= '0;
                r_sample_err_cnt  <= '0;
                r_bit_err_cnt     <= '0;
                r_first_err_valid <= 1'b0;
                r_first_err_idx   <= '0;
            end else begin
                r_s1_valid <= w_fire;
                if (w_fire) begin
                    r_s1_x   <= (dut_data ^ ref_data) & mask;
                    r_s1_idx <= r_idx;
                    r_idx    <= r_idx + CNT_W'(1);
                end
                if (w_s1_err) begin
                    r_err_pulse      <= 1'b1;
                    r_err_idx        <= r_s1_idx;
                    r_sample_err_cnt <= w_sample_next;
                    r_bit_err_cnt    <= w_bit_next;
                    if (!r_first_err_valid) begin
                        r_first_err_valid <= 1'b1;
                        r_first_err_idx   <= r_s1_idx;
                    end
                end
            end
        end
    end

    assign dut_ready       = w_fire;
    assign ref_ready       = w_fire;
    assign busy            = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign done            = (r_state == S_DONE);
    assign err_pulse       = r_err_pulse;
    assign err_idx         = r_err_idx;
    assign sample_err_cnt  = r_sample_err_cnt;
    assign bit_err_cnt     = r_bit_err_cnt;
    assign first_err_valid = r_first_err_valid;
    assign first_err_idx   = r_first_err_idx;

endmodule

// File: tb/tb_awgn_err_check.sv
// Directed bench for awgn_err_check: an 8-sample checker for function/timing and a
// 4-bit-counter instance for saturation.
module tb_awgn_err_check;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, dut_valid, ref_valid;
    logic [15:0] mask, dut_data, ref_data;
    logic        dut_ready, ref_ready, busy, done, err_pulse, first_err_valid;
    logic [31:0] err_idx, sample_err_cnt, bit_err_cnt, first_err_idx;

    logic        start2, dut_valid2, ref_valid2;
    logic [15:0] mask2, dut_data2, ref_data2;
    logic        dut_ready2, ref_ready2, busy2, done2, err_pulse2, first_err_valid2;
    logic [3:0]  err_idx2, sample_err_cnt2, bit_err_cnt2, first_err_idx2;

    awgn_err_check #(.W(16), .N_SAMPLES(8), .CNT_W(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mask(mask),
        .dut_valid(dut_valid), .dut_data(dut_data), .dut_ready(dut_ready),
        .ref_valid(ref_valid), .ref_data(ref_data), .ref_ready(ref_ready),
        .busy(busy), .done(done), .err_pulse(err_pulse), .err_idx(err_idx),
        .sample_err_cnt(sample_err_cnt), .bit_err_cnt(bit_err_cnt),
        .first_err_valid(first_err_valid), .first_err_idx(first_err_idx)
    );

    awgn_err_check #(.W(16), .N_SAMPLES(16), .CNT_W(4)) u_sat (
        .clk(clk), .rst_n(rst_n), .start(start2), .mask(mask2),
        .dut_valid(dut_valid2), .dut_data(dut_data2), .dut_ready(dut_ready2),
        .ref_valid(ref_valid2), .ref_data(ref_data2), .ref_ready(ref_ready2),
        .busy(busy2), .done(done2), .err_pulse(err_pulse2), .err_idx(err_idx2),
        .sample_err_cnt(sample_err_cnt2), .bit_err_cnt(bit_err_cnt2),
        .first_err_valid(first_err_valid2), .first_err_idx(first_err_idx2)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [15:0] dv [8];
    logic [15:0] rv [8];
    int          m_serr, m_berr, m_last;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input string tag);
        dut_valid = 1'b0;
        ref_valid = 1'b0;
        start     = 1'b1;
        step();
        start = 1'b0;
        check({tag, "_busy"}, busy, 1'b1);
        check({tag, "_clr_serr"}, sample_err_cnt, 0);
        check({tag, "_clr_first"}, first_err_valid, 1'b0);
    endtask

    // Streams dv/rv back to back, checks err_pulse timing per sample and final counts.
    task automatic do_run(input string tag, input logic [15:0] msk);
        logic [15:0] x, x_prev;
        mask   = msk;
        m_serr = 0;
        m_berr = 0;
        m_last = 0;
        x_prev = '0;
        for (int k = 0; k < 8; k++) begin
            x         = (dv[k] ^ rv[k]) & msk;
            dut_valid = 1'b1;
            ref_valid = 1'b1;
            dut_data  = dv[k];
            ref_data  = rv[k];
            start     = (k == 5);
            step();
            if (k > 0) check($sformatf("%s_pulse%0d", tag, k - 1), err_pulse, |x_prev);
            if (x != 0) begin
                m_serr++;
                m_berr += $countones(x);
                m_last = k;
            end
            x_prev = x;
        end
        dut_valid = 1'b0;
        ref_valid = 1'b0;
        start     = 1'b0;
        check({tag, "_drain_busy"}, busy, 1'b1);
        check({tag, "_drain_done"}, done, 1'b0);
        step();
        check({tag, "_pulse7"}, err_pulse, |x_prev);
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_serr"}, sample_err_cnt, m_serr);
        check({tag, "_berr"}, bit_err_cnt, m_berr);
        if (m_serr > 0) check({tag, "_erridx"}, err_idx, m_last);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0; dut_valid = 1'b0; ref_valid = 1'b0;
        mask = 16'hFFFF; dut_data = '0; ref_data = '0;
        start2 = 1'b0; dut_valid2 = 1'b0; ref_valid2 = 1'b0;
        mask2 = 16'hFFFF; dut_data2 = '0; ref_data2 = '0;
        step();
        step();

        // Reset values
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_pulse", err_pulse, 1'b0);
        check("rst_serr", sample_err_cnt, 0);
        check("rst_berr", bit_err_cnt, 0);
        check("rst_first_v", first_err_valid, 1'b0);

        // No fire after reset release until start, even with both streams valid
        rst_n = 1'b1;
        dut_valid = 1'b1; ref_valid = 1'b1;
        dut_data = 16'h1234; ref_data = 16'h4321;
        #1 check("idle_noready", dut_ready, 1'b0);
        step(); step(); step();
        check("idle_serr", sample_err_cnt, 0);
        check("idle_pulse", err_pulse, 1'b0);
        check("idle_busy", busy, 1'b0);

        // Identical streams
        dv = '{16'h0000, 16'h1111, 16'hA5A5, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0F0F, 16'hC3C3};
        rv = dv;
        start_run("clean");
        do_run("clean", 16'hFFFF);
        check("clean_serr0", sample_err_cnt, 0);
        check("clean_berr0", bit_err_cnt, 0);
        check("clean_first_v", first_err_valid, 1'b0);
        step(); step(); step();
        check("done_hold", done, 1'b1);
        check("done_hold_serr", sample_err_cnt, 0);

        // Sample 3 differs by 16'h0005
        rv[3] = dv[3] ^ 16'h0005;
        start_run("err3");
        do_run("err3", 16'hFFFF);
        check("err3_serr1", sample_err_cnt, 1);
        check("err3_berr2", bit_err_cnt, 2);
        check("err3_first_v", first_err_valid, 1'b1);
        check("err3_first_idx", first_err_idx, 3);
        check("err3_err_idx", err_idx, 3);

        // Same stream, bit 0 masked off
        start_run("mask");
        do_run("mask", 16'hFFFE);
        check("mask_serr1", sample_err_cnt, 1);
        check("mask_berr1", bit_err_cnt, 1);

        // ref_valid toggles while dut_valid stays high
        dv = '{16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 16'h0007, 16'h0008};
        rv = dv;
        rv[2] = dv[2] ^ 16'h0100;
        rv[6] = dv[6] ^ 16'h00F0;
        start_run("tog");
        mask = 16'hFFFF;
        begin
            int k = 0;
            for (int c = 0; c < 40 && k < 8; c++) begin
                dut_valid = 1'b1;
                dut_data  = dv[k];
                ref_valid = (c % 2 == 1);
                ref_data  = ref_valid ? rv[k] : 16'hDEAD;
                #1;
                check($sformatf("tog_dready%0d", c), dut_ready, ref_valid);
                check($sformatf("tog_rready%0d", c), ref_ready, ref_valid);
                step();
                if (ref_valid) k++;
            end
            check("tog_all_fired", k, 8);
        end
        dut_valid = 1'b0; ref_valid = 1'b0;
        step();
        check("tog_done", done, 1'b1);
        check("tog_serr", sample_err_cnt, 2);
        check("tog_berr", bit_err_cnt, 5);
        check("tog_first_idx", first_err_idx, 2);
        check("tog_err_idx", err_idx, 6);

        // Reset mid-run at fire 4, then a fresh run
        rv = dv;
        rv[1] = dv[1] ^ 16'h8000;
        start_run("rstmid");
        for (int k = 0; k < 4; k++) begin
            dut_valid = 1'b1; ref_valid = 1'b1;
            dut_data = dv[k]; ref_data = rv[k];
            step();
        end
        check("rstmid_pre_serr", sample_err_cnt, 1);
        dut_data = dv[4]; ref_data = rv[4];
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_done", done, 1'b0);
        check("rstmid_pulse", err_pulse, 1'b0);
        check("rstmid_dready", dut_ready, 1'b0);
        check("rstmid_rready", ref_ready, 1'b0);
        check("rstmid_first_v", first_err_valid, 1'b0);
        check("rstmid_serr", sample_err_cnt, 0);
        check("rstmid_berr", bit_err_cnt, 0);
        check("rstmid_erridx", err_idx, 0);
        check("rstmid_firstidx", first_err_idx, 0);
        step();
        rst_n = 1'b1;
        step();
        check("rstmid_idle_noready", dut_ready, 1'b0);
        rv = dv;
        rv[0] = dv[0] ^ 16'h0003;
        start_run("rerun");
        do_run("rerun", 16'hFFFF);
        check("rerun_first_idx", first_err_idx, 0);
        check("rerun_err_idx", err_idx, 0);
        check("rerun_serr", sample_err_cnt, 1);
        check("rerun_berr", bit_err_cnt, 2);

        // Saturation with 4-bit counters: 16 samples of 16 bit errors each
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        dut_valid2 = 1'b1; ref_valid2 = 1'b1;
        dut_data2 = 16'hFFFF; ref_data2 = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            step();
            if (k == 1) check("sat_berr_first", bit_err_cnt2, 4'd15);
        end
        dut_valid2 = 1'b0; ref_valid2 = 1'b0;
        step();
        check("sat_done", done2, 1'b1);
        check("sat_berr", bit_err_cnt2, 4'd15);
        check("sat_serr", sample_err_cnt2, 4'd15);
        check("sat_erridx", err_idx2, 4'd15);
        check("sat_first_idx", first_err_idx2, 4'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
